recip_lut_bank: RTL and testbench
=================================

RECIP_LUT_BANK -- requirements
Module: recip_lut_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, entry width in bits.
REQ-002 The block SHALL have parameter FRAC_W, default 8, fraction bits of the reciprocal scale; FRAC_W < DATA_W.
REQ-003 The block SHALL have parameter DEPTH, default 12, number of table entries.
REQ-004 The block SHALL have parameter ADDR_W, default 4, address width; 2^ADDR_W >= DEPTH.
REQ-005 The block SHALL have parameter NUM_CH, default 2, number of independent read channels.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port init_req, input, 1, a pulse that restores the default contents.
REQ-009 The block SHALL have port rd_valid, input, NUM_CH, per-channel read request.
REQ-010 The block SHALL have port rd_adr, input, NUM_CH*ADDR_W, channel c uses bits [c*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd_ready, output, 1, high only in state READY.
REQ-012 The block SHALL have port rd_data, output, NUM_CH*DATA_W, channel c uses bits [c*DATA_W +: DATA_W].
REQ-013 The block SHALL have port rd_dvalid, output, NUM_CH, per-channel one-cycle result strobe.
REQ-014 The block SHALL have port rd_err, output, NUM_CH, per-channel out-of-range flag, qualified by rd_dvalid.
REQ-015 The block SHALL have ports wr_en (input, 1), wr_adr (input, ADDR_W) and wr_data (input, DATA_W), the single write port.
REQ-016 The block SHALL have port busy, output, 1, high in state INIT.

Function
REQ-017 The default for entry 0 SHALL be 2^FRAC_W-1; for entry i>0 it SHALL be floor(2^FRAC_W/(i+1)), computed at elaboration time (defaults: 255,128,85,64,51,42,36,32,28,25,23,21).
REQ-018 The FSM SHALL have two states, INIT and READY; reset and init_req (any state) enter INIT with the init counter at 0.
REQ-019 In INIT the block SHALL write default[cnt] to entry cnt each cycle, increment cnt, and go to READY in the cycle after writing entry DEPTH-1 (INIT lasts exactly DEPTH cycles).
REQ-020 An init_req asserted during INIT SHALL restart the counter at 0.
REQ-021 In INIT, rd_valid and wr_en SHALL be ignored: no rd_dvalid is produced and no user write occurs.
REQ-022 A READY-state read on channel c SHALL produce rd_dvalid[c]=1 exactly one cycle later, with rd_data[c] equal to the entry contents at the request edge.
REQ-023 If rd_adr for channel c is >= DEPTH, the block SHALL return rd_data[c]=0 and rd_err[c]=1 with the same latency.
REQ-024 Channels SHALL be fully independent: any number of channels, including all channels on the same address, SHALL be served in the same cycle.
REQ-025 rd_data[c] SHALL hold its last value when there is no new request, and rd_err[c] SHALL be low when rd_dvalid[c] is low.
REQ-026 A READY-state wr_en with wr_adr < DEPTH SHALL update the entry at the clock edge; wr_adr >= DEPTH SHALL be silently dropped.
REQ-027 When a read and a write hit the same address in the same cycle, the read SHALL return the old contents (read-before-write).
REQ-028 When init_req and wr_en occur in the same cycle, init_req SHALL win and the write SHALL be dropped.
REQ-029 When init_req and a read occur in the same cycle, the read SHALL still be served from pre-init contents if the state was READY.

Reset
REQ-030 While rst is high, the block SHALL hold state=INIT, cnt=0, rd_dvalid=0, rd_err=0, rd_data=0 and busy=1; rd_ready=0 is implied.
REQ-031 Reset asserted mid-INIT or mid-read SHALL abort the operation and discard any pending rd_dvalid.

Verification
REQ-032 Bench SHALL verify: release rst -> busy=1 for 12 cycles, then rd_ready=1; reading addresses 0..11 returns 255,128,85,64,51,42,36,32,28,25,23,21.
REQ-033 Bench SHALL verify: channel 0 reads addr 3 and channel 1 reads addr 11 in the same cycle -> next cycle rd_dvalid=2'b11, data 64 and 21.
REQ-034 Bench SHALL verify: read addr 13 -> rd_err=1 and rd_data=0 one cycle later; the other channel is unaffected.
REQ-035 Bench SHALL verify: write 16'h1234 to addr 5 while reading addr 5 -> that read returns 42, and the next read returns 16'h1234.
REQ-036 Bench SHALL verify: init_req after the write -> busy for 12 cycles, rd_valid is ignored meanwhile, and addr 5 then reads 42.
REQ-037 Bench SHALL verify: rst asserted on the cycle after a read request -> no rd_dvalid, and all outputs are 0.

Source files
------------

// File: rtl/recip_lut_bank.sv
// recip_lut_bank
// ----------------------------------------------------------------------------
// Multi-channel lookup table of fixed-point reciprocals. The table holds DEPTH
// entries that are refilled with floor(2^FRAC_W/(i+1)) (entry 0 saturates to
// 2^FRAC_W-1) by an INIT sequence after reset or an init_req pulse. Once READY,
// the table serves NUM_CH independent registered read channels and accepts
// writes through a single write port.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous active-high reset
//   init_req   pulse: restart the default-contents fill (from any state)
//   rd_valid   per-channel read request
//   rd_adr     per-channel read address, channel c at [c*ADDR_W +: ADDR_W]
//   rd_ready   high while the table is READY
//   rd_data    per-channel read result, channel c at [c*DATA_W +: DATA_W]
//   rd_dvalid  per-channel one-cycle result strobe
//   rd_err     per-channel out-of-range flag, qualified by rd_dvalid
//   wr_en      write strobe (honoured only in READY)
//   wr_adr     write address; addresses >= DEPTH are dropped
//   wr_data    write data
//   busy       high while the INIT fill is running
// ----------------------------------------------------------------------------
module recip_lut_bank #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_req,
  input  logic [NUM_CH-1:0]        rd_valid,
  input  logic [NUM_CH*ADDR_W-1:0] rd_adr,
  output logic                     rd_ready,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0]        rd_dvalid,
  output logic [NUM_CH-1:0]        rd_err,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_adr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Default contents are folded into a constant at elaboration so the fill
  // logic is a plain ROM lookup indexed by the init counter.
  function automatic logic [DEPTH*DATA_W-1:0] build_rom();
    logic [DEPTH*DATA_W-1:0] rom;
    rom = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        rom[i*DATA_W +: DATA_W] = DATA_W'((1 << FRAC_W) - 1);
      end else begin
        rom[i*DATA_W +: DATA_W] = DATA_W'((1 << FRAC_W) / (i + 1));
      end
    end
    return rom;
  endfunction

  localparam logic [DEPTH*DATA_W-1:0] DEFAULT_ROM = build_rom();
  localparam logic [ADDR_W-1:0]       LAST_ADR    = ADDR_W'(DEPTH - 1);

  // One extra bit so the comparison also works when DEPTH == 2^ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   next_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   ch_adr [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_adr[c] = rd_adr[c*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // init_req overrides everything, including an in-progress fill, so the
  // counter always restarts from entry 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    rd_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (cnt == LAST_ADR) begin
          next_state = READY;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      READY: begin
        rd_ready = 1'b1;
      end
      default: begin
        next_state = INIT;
        next_cnt   = '0;
      end
    endcase
    if (init_req) begin
      next_state = INIT;
      next_cnt   = '0;
    end
  end

  // The table itself is not reset: the INIT fill that follows reset rewrites
  // every entry. A user write in the same cycle as init_req is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt] <= DEFAULT_ROM[int'(cnt)*DATA_W +: DATA_W];
      end else if (wr_en && !init_req && in_range(wr_adr)) begin
        mem[wr_adr] <= wr_data;
      end
    end
  end

  // Reads sample the array before this edge's write lands, which gives
  // read-before-write on an address collision. A read issued in READY is
  // still served even if init_req arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data   <= '0;
      rd_dvalid <= '0;
      rd_err    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_dvalid[c] <= 1'b0;
        rd_err[c]    <= 1'b0;
        if (state == READY && rd_valid[c]) begin
          rd_dvalid[c] <= 1'b1;
          if (in_range(ch_adr[c])) begin
            rd_data[c*DATA_W +: DATA_W] <= mem[ch_adr[c]];
          end else begin
            rd_data[c*DATA_W +: DATA_W] <= '0;
            rd_err[c]                   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_recip_lut_bank.sv
// tb_recip_lut_bank
// ----------------------------------------------------------------------------
// Self-checking bench for recip_lut_bank with default parameters: directed
// table of read vectors, hand-written multi-cycle sequences around INIT,
// collisions and reset, and a randomized phase checked against an array model
// of the table contents.
// ----------------------------------------------------------------------------
module tb_recip_lut_bank;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;
  localparam int NUM_CH = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     init_req;
  logic [NUM_CH-1:0]        rd_valid;
  logic [NUM_CH*ADDR_W-1:0] rd_adr;
  logic                     rd_ready;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0]        rd_dvalid;
  logic [NUM_CH-1:0]        rd_err;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_adr;
  logic [DATA_W-1:0]        wr_data;
  logic                     busy;

  recip_lut_bank #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .rd_valid (rd_valid),
    .rd_adr   (rd_adr),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_dvalid(rd_dvalid),
    .rd_err   (rd_err),
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dv;
    logic [1:0]  err;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[$];
  logic [15:0] spec_vals [12] = '{16'd255, 16'd128, 16'd85, 16'd64, 16'd51, 16'd42,
                                  16'd36, 16'd32, 16'd28, 16'd25, 16'd23, 16'd21};
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_data [NUM_CH];

  function automatic logic [15:0] ref_default(input int i);
    if (i == 0) return 16'((1 << FRAC_W) - 1);
    return 16'((1 << FRAC_W) / (i + 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, cross the rising edge, sample at the falling edge.
  task automatic applyStimulus(input logic r, input logic ir, input logic [1:0] v,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic we, input logic [3:0] wa, input logic [15:0] wd);
    rst      = r;
    init_req = ir;
    rd_valid = v;
    rd_adr   = {a1, a0};
    wr_en    = we;
    wr_adr   = wa;
    wr_data  = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [1:0] dv, input logic [1:0] err);
    vec_t t;
    t.valid = v; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.dv = dv; t.err = err;
    return t;
  endfunction

  initial begin
    int n;
    logic [1:0]  v, exp_dv, exp_err;
    logic [3:0]  a0, a1, wa;
    logic        we;
    logic [15:0] wd;
    logic [3:0]  adr_c;

    for (int i = 0; i < 12; i++) begin
      vecs.push_back(mk(2'b11, 4'(i), 4'(11 - i), spec_vals[i], spec_vals[11 - i], 2'b11, 2'b00));
    end
    vecs.push_back(mk(2'b11, 4'd3,  4'd11, 16'd64, 16'd21, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 4'd13, 4'd2,  16'd0,  16'd85, 2'b11, 2'b01));
    vecs.push_back(mk(2'b11, 4'd7,  4'd15, 16'd32, 16'd0,  2'b11, 2'b10));
    vecs.push_back(mk(2'b11, 4'd5,  4'd5,  16'd42, 16'd42, 2'b11, 2'b00));

    // Reset held with reads pending: everything must stay cleared.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 2'b11, 4'd1, 4'd2, 1'b0, 4'd0, 16'd0);
    checkOutput("rst_busy",   32'(busy),      32'd1);
    checkOutput("rst_ready",  32'(rd_ready),  32'd0);
    checkOutput("rst_dvalid", 32'(rd_dvalid), 32'd0);
    checkOutput("rst_err",    32'(rd_err),    32'd0);
    checkOutput("rst_data",   32'(rd_data),   32'd0);

    // Power-up fill; reads and a write to entry 3 must be ignored meanwhile.
    n = 1;
    for (int k = 0; k < 40 && busy; k++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 4'd1, 4'd2, 1'b1, 4'd3, 16'hFFFF);
      checkOutput("pwr_init_dvalid", 32'(rd_dvalid), 32'd0);
      if (busy) n++;
    end
    checkOutput("pwr_init_len", 32'(n), 32'd12);
    checkOutput("pwr_ready", 32'(rd_ready), 32'd1);

    // Directed read table.
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b0, vecs[i].valid, vecs[i].a0, vecs[i].a1, 1'b0, 4'd0, 16'd0);
      checkOutput($sformatf("vec%0d_data0", i), 32'(rd_data[15:0]),  32'(vecs[i].d0));
      checkOutput($sformatf("vec%0d_data1", i), 32'(rd_data[31:16]), 32'(vecs[i].d1));
      checkOutput($sformatf("vec%0d_dvalid", i), 32'(rd_dvalid), 32'(vecs[i].dv));
      checkOutput($sformatf("vec%0d_err", i), 32'(rd_err), 32'(vecs[i].err));
    end

    // Idle cycle holds data; single-channel read leaves the other channel alone.
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
    checkOutput("hold_data",   32'(rd_data),   {16'd42, 16'd42});
    checkOutput("hold_dvalid", 32'(rd_dvalid), 32'd0);
    checkOutput("hold_err",    32'(rd_err),    32'd0);
    applyStimulus(1'b0, 1'b0, 2'b01, 4'd1, 4'd9, 1'b0, 4'd0, 16'd0);
    checkOutput("single_data",   32'(rd_data),   {16'd42, 16'd128});
    checkOutput("single_dvalid", 32'(rd_dvalid), 32'd1);

    // Read-before-write collision on entry 5, then the new value.
    applyStimulus(1'b0, 1'b0, 2'b11, 4'd5, 4'd5, 1'b1, 4'd5, 16'h1234);
    checkOutput("rbw_data", 32'(rd_data), {16'd42, 16'd42});
    applyStimulus(1'b0, 1'b0, 2'b01, 4'd5, 4'd0, 1'b1, 4'd14, 16'hFFFF);
    checkOutput("rbw_new_data", 32'(rd_data), {16'd42, 16'h1234});

    // init_req with a read (served from old contents) and a write (dropped).
    applyStimulus(1'b0, 1'b1, 2'b01, 4'd5, 4'd0, 1'b1, 4'd5, 16'hBEEF);
    checkOutput("initreq_dvalid", 32'(rd_dvalid), 32'd1);
    checkOutput("initreq_data0",  32'(rd_data[15:0]), 32'h1234);
    checkOutput("initreq_busy",   32'(busy), 32'd1);
    n = 1;
    for (int k = 0; k < 40 && busy; k++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 4'd5, 4'd0, 1'b1, 4'd5, 16'hDEAD);
      checkOutput("init_dvalid", 32'(rd_dvalid), 32'd0);
      if (busy) n++;
    end
    checkOutput("init_len", 32'(n), 32'd12);
    checkOutput("init_ready", 32'(rd_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b11, 4'd5, 4'd0, 1'b0, 4'd0, 16'd0);
    checkOutput("post_init_data",   32'(rd_data),   {16'd255, 16'd42});
    checkOutput("post_init_dvalid", 32'(rd_dvalid), 32'd3);

    // init_req during INIT restarts the fill: 4 cycles lost plus a full 12.
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
    n = 1;
    for (int k = 0; k < 60 && busy; k++) begin
      applyStimulus(1'b0, (n == 4), 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
      if (busy) n++;
    end
    checkOutput("restart_len", 32'(n), 32'd16);

    // Randomized traffic against the array model.
    for (int i = 0; i < DEPTH; i++) model_mem[i] = ref_default(i);
    exp_data[0] = 16'd42;
    exp_data[1] = 16'd255;
    for (int k = 0; k < 300; k++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      if (k % 7 == 0) a1 = a0;
      if (k % 5 == 0) wa = a0;
      exp_dv  = v;
      exp_err = 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
        adr_c = (c == 0) ? a0 : a1;
        if (v[c]) begin
          if (int'(adr_c) < DEPTH) begin
            exp_data[c] = model_mem[adr_c];
          end else begin
            exp_data[c] = 16'd0;
            exp_err[c]  = 1'b1;
          end
        end
      end
      applyStimulus(1'b0, 1'b0, v, a0, a1, we, wa, wd);
      if (we && int'(wa) < DEPTH) model_mem[wa] = wd;
      checkOutput("rnd_data",   32'(rd_data),   {exp_data[1], exp_data[0]});
      checkOutput("rnd_dvalid", 32'(rd_dvalid), 32'(exp_dv));
      checkOutput("rnd_err",    32'(rd_err),    32'(exp_err));
    end

    // Reset lands on the edge that would deliver a pending read.
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'd1, 4'd13, 1'b0, 4'd0, 16'd0);
    checkOutput("rst_rd_dvalid", 32'(rd_dvalid), 32'd0);
    checkOutput("rst_rd_err",    32'(rd_err),    32'd0);
    checkOutput("rst_rd_data",   32'(rd_data),   32'd0);
    checkOutput("rst_rd_busy",   32'(busy),      32'd1);
    checkOutput("rst_rd_ready",  32'(rd_ready),  32'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
    checkOutput("rst_hold_dvalid", 32'(rd_dvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
